// File: rtl/dig_display_ctrl.sv
// dig_display_ctrl: write-only 32-bit display register scanned across eight active-low 7-seg digits.
// Define DIG_BLANK_LEADING_ZERO_EN to blank digits above the most significant nonzero nibble.
module dig_display_ctrl #(
    parameter logic [31:0] DIG_ADDR = 32'hFFFF_F000,
    parameter int          SCAN_DIV = 50000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);
    localparam logic [7:0] HEX7 [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };
    logic [31:0]      disp_q, disp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       dig_en_q, dig_en_d, seg_q, seg_d;
    logic             wrap, blank;
    always_comb begin
        disp_d = disp_q;
        for (int k = 0; k < 4; k++)
            if (addr == DIG_ADDR && we[k]) disp_d[8*k +: 8] = wdata[8*k +: 8];
    end
    assign wrap  = cnt_q == CNT_W'(SCAN_DIV - 1);
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    assign idx_d = idx_q + 3'(wrap);
`ifdef DIG_BLANK_LEADING_ZERO_EN
    logic [2:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < 8; i++)
            if (disp_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
    assign blank = idx_q > msd;
`else
    assign blank = 1'b0;
`endif
    // Outputs are built from the current idx/disp, giving one cycle of latency to the pins.
    assign dig_en_d = ~(8'b1 << idx_q);
    assign seg_d    = blank ? 8'hFF : HEX7[disp_q[4*idx_q +: 4]];
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            dig_en_q <= 8'hFF;
            seg_q    <= 8'hFF;
        end else begin
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
        end
    end
    assign dig_en = dig_en_q;
    assign seg    = seg_q;
endmodule

// File: tb/tb_dig_display_ctrl.sv
// tb_dig_display_ctrl: directed and random checks of the scanned display against a frame-position model.
module tb_dig_display_ctrl;
    localparam logic [31:0] DA = 32'hFFFF_F000;
    localparam int SD = 4;
`ifdef DIG_BLANK_LEADING_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [7:0] HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = DA, wdata = '0;
    logic [3:0]  we = '0;
    logic [7:0]  dig_en, seg;
    int          tests = 0, fails = 0;
    int          n = 0;
    logic [31:0] disp_m = '0;
    logic [7:0]  old_seg_exp;

    dig_display_ctrl #(.DIG_ADDR(DA), .SCAN_DIV(SD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .dig_en(dig_en), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [31:0] d, input int idx);
        int msd = 0;
        for (int i = 1; i < 8; i++) if (d[4*i +: 4] != 4'h0) msd = i;
        return (BLANK && idx > msd) ? 8'hFF : HEX[d[4*idx +: 4]];
    endfunction

    // One clock edge: the n-th edge after reset release shows digit (n / SD) % 8 of the pre-edge register.
    task automatic step();
        logic [7:0] e_en, e_seg;
        int idx;
        @(posedge clk);
        if (rst) begin
            e_en = 8'hFF; e_seg = 8'hFF; n = 0; disp_m = '0;
        end else begin
            idx   = (n / SD) % 8;
            e_en  = ~(8'd1 << idx);
            e_seg = seg_of(disp_m, idx);
            if (addr == DA)
                for (int k = 0; k < 4; k++) if (we[k]) disp_m[8*k +: 8] = wdata[8*k +: 8];
            n++;
        end
        #1;
        chk("dig_en", dig_en, e_en);
        chk("seg", seg, e_seg);
    endtask

    task automatic steps(input int c);
        for (int i = 0; i < c; i++) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addr = a; we = w; wdata = d;
        step();
        we = '0;
    endtask

    initial begin
        steps(3);
        chk("rst_dig_en", dig_en, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        rst = 1'b0;
        step();
        chk("first_dig_en", dig_en, 8'hFE);
        chk("first_seg", seg, 8'h03);
        steps(4);
        chk("slot1_dig_en", dig_en, 8'hFD);
        wr(DA, 4'hF, 32'h8765_4321);
        steps(8 * SD + 2);
        wr(DA, 4'b0100, 32'hAABB_CCDD);
        steps(8 * SD);
        wr(DA + 32'd4, 4'hF, 32'h1234_5678);
        wr(DA, 4'h0, 32'h1234_5678);
        steps(8 * SD);
        while (n % SD != 0) step();
        old_seg_exp = seg_of(disp_m, (n / SD) % 8);
        wr(DA, 4'hF, 32'hFFFF_FFFF);
        chk("coinc_old_nibble", seg, old_seg_exp);
        step();
        chk("coinc_new_nibble", seg, 8'h71);
        wr(DA, 4'hF, 32'h0000_00A5);
        steps(8 * SD);
        wr(DA, 4'hF, 32'h0);
        steps(8 * SD);
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            addr  = ($urandom_range(0, 3) == 0) ? $urandom : DA;
            we    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            wdata = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_0F0F);
            step();
        end
        rst = 1'b0; we = '0;
        steps(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dig_display_ctrl.md
Name: dig_display_ctrl

Overview:
- Peripheral-side responder for the 7-seg write port that the CPU bridge drives: it receives `addr`, `we` and `wdata` from the bridge and holds a 32-bit display register.
- It time-multiplexes the register across eight hex digits, with active-low anodes and cathodes.
- It sits at the board top, between the bridge's dig port and the board display pins.
- It is write-only; it returns no read data.

Parameters:
- DIG_ADDR, 32'hFFFF_F000, address the block responds to; must equal `PERI_ADDR_DIG.
- SCAN_DIV, 50000, clk cycles per digit slot; legal range >= 2.
- CNT_W, 16, width of the scan counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, shared with CPU and bridge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  address from the bridge.
- we  input  4  byte-lane write enables, already gated by the bridge.
- wdata  input  32  write data.
- dig_en  output  8  digit anodes, active-low; bit i selects digit i, digit 0 is rightmost.
- seg  output  8  cathodes {CA,CB,CC,CD,CE,CF,CG,DP}, active-low.

Behaviour:
- Clock and reset:
  - Single clock domain. All state is updated on the rising edge of clk.
  - rst is synchronous and active-high.
- Reset state:
  - Display register disp = 32'h0, scan counter = 0, digit index idx = 0.
  - Outputs: dig_en = 8'hFF and seg = 8'hFF (all dark) while rst is sampled high.
- Write path:
  - Condition: (addr == DIG_ADDR) and we[k] = 1.
  - Action: disp[8k+7:8k] <= wdata[8k+7:8k] at that clock edge. Lanes with we[k] = 0 are unchanged.
  - If we = 0 or the address mismatches: no change.
  - Multiple lanes may be written in one cycle. A 4'b0000 enable at the matching address is a no-op.
- Scan counter:
  - Increments by 1 each cycle.
  - At SCAN_DIV-1 it returns to 0 and idx <= idx+1. idx is 3 bits and wraps 7 -> 0.
  - A digit slot therefore lasts exactly SCAN_DIV cycles; a full frame lasts 8*SCAN_DIV cycles.
- Output registers:
  - dig_en <= ~(8'b1 << idx); exactly one bit is low outside reset.
  - seg <= hex7(disp[4*idx+3 : 4*idx]), using the current idx and current disp.
  - Latency: 1 cycle from an idx change, or from a disp change, to the pins.
  - A write to the currently displayed nibble appears on seg on the cycle after the write edge.
- Write coincident with idx advance: the new idx and the old disp are used in that cycle; the new disp value appears one cycle later.
- hex7 table (DP bit always 1): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 A=11 B=C1 C=63 D=85 E=61 F=71.
- Reset in the middle of a slot or frame: on the next edge, counter, idx and disp clear and the outputs go dark. Scanning restarts at digit 0 on the first cycle after rst falls.

Optional Feature:
- Macro: DIG_BLANK_LEADING_ZERO_EN.
- Defined:
  - Let msd = index of the highest nonzero nibble of disp, or 0 if disp == 0.
  - For idx > msd: seg <= 8'hFF, and dig_en still cycles normally.
  - Digit 0 always shows (displays "0" when disp == 0).
  - msd is computed combinationally from disp, so the same 1-cycle output latency applies.
- Undefined: all eight digits always show their hex value, including leading zeros.

Test Plan (SCAN_DIV = 4):
- Reset behaviour: hold rst for 3 cycles, then release -> dig_en = FF and seg = FF during reset. First cycle after release: dig_en = FE, seg = 03. dig_en = FD exactly 4 cycles later.
- Full-word write: addr = DIG_ADDR, we = F, wdata = 32'h8765_4321 -> over one frame seg sequence is 9F, 25, 0D, 99, 49, 41, 1F, 01 on dig_en FE, FD, FB, F7, EF, DF, BF, 7F, then wrap to FE.
- Byte-lane write: after the full-word write, we = 4'b0100, wdata = 32'hAABB_CCDD -> disp = 32'h87BB_4321. Digit 4 shows C1, digit 5 shows C1, other digits unchanged.
- Address filter: we = F at addr = DIG_ADDR+4, and separately we = 0 at DIG_ADDR -> disp is unchanged in both cases; the seg sequence is identical to the prior frame.
- Coincident write: write 32'hFFFF_FFFF on the idx-advance edge -> the next cycle shows the new digit with the old nibble; the following cycle shows 71.
- Optional feature: with DIG_BLANK_LEADING_ZERO_EN, write 32'h0000_00A5 -> digits 0 and 1 show 49 and 11; digits 2-7 show FF. Then write 0 -> digit 0 shows 03 and the others show FF. Without the macro, digits 2-7 show 03.
